// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for a combinational 4-bit ALU: accepts commands,
// drives ALU operands for one cycle, and writes the result back to a 4x4 register file.
module alu_issue_ctrl #(
  parameter int NREG = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_ld,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_sel,
  output logic       alu_en,
  input  logic [3:0] alu_result,
  output logic       done,
  output logic       zero,
  output logic       err,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0] state;
  logic [3:0] regs [NREG];
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [3:0] res_q;
  logic       err_q;
  logic       accept;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == 4'b0011) || (op == 4'b1011);
  endfunction

  // Gating with rst_n keeps cmd_ready low for as long as reset is held.
  assign cmd_ready = rst_n && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign alu_en    = (state == EXEC);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = op_q;

  assign done      = (state == WB);
  assign zero      = (state == WB) && (res_q == 4'h0);
  assign err       = (state == WB) && err_q;

  assign dbg_data  = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        // IDLE -> EXEC/WB: operands are sampled here, so ALU inputs only move on an ALU command
        IDLE: begin
          if (accept) begin
            rd_q  <= cmd_rd;
            err_q <= 1'b0;
            if (cmd_ld) begin
              res_q <= cmd_imm;
              state <= WB;
            end else begin
              op_q  <= cmd_op;
              a_q   <= regs[cmd_rs1];
              b_q   <= regs[cmd_rs2];
              state <= EXEC;
            end
          end
        end
        // EXEC -> WB: capture the combinational ALU return
        EXEC: begin
          res_q <= alu_result;
          err_q <= is_div_op(op_q) && (b_q == 4'h0);
          state <= WB;
        end
        // WB -> IDLE: commit unless the command faulted
        WB: begin
          if (!err_q) begin
            regs[rd_q] <= res_q;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed table, busy/reset corner sequences, and random
// commands checked against a transaction-level register-file model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_ld = 1'b0;
  logic [3:0] cmd_op = '0;
  logic [1:0] cmd_rd = '0;
  logic [1:0] cmd_rs1 = '0;
  logic [1:0] cmd_rs2 = '0;
  logic [3:0] cmd_imm = '0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_sel;
  logic       alu_en;
  logic [3:0] alu_result;
  logic       done;
  logic       zero;
  logic       err;
  logic [1:0] dbg_addr = '0;
  logic [3:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0] m_regs [4];

  alu_issue_ctrl #(.NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_en(alu_en),
    .alu_result(alu_result), .done(done), .zero(zero), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU sitting downstream of the controller.
  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    case (sel)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return (b == 0) ? 4'hF : a / b;
      4'b0100: return ~a;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b1011: return (b == 0) ? 4'hF : a % b;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk(name, dbg_data, m_regs[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
  endtask

  // Issue one command, check its EXEC/WB behaviour against the model, then update the model.
  task automatic issue(input logic ld, input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm,
                       output logic o_zero, output logic o_err, output int o_acc);
    int n;
    logic [3:0] val;
    logic e;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) chk("ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_ld = ld; cmd_op = op; cmd_rd = rd;
    cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    @(posedge clk); #1;
    o_acc = cyc;
    cmd_valid = 1'b0;
    val = ld ? imm : alu_f(m_regs[rs1], m_regs[rs2], op);
    e = !ld && (op == 4'b0011 || op == 4'b1011) && (m_regs[rs2] == 0);
    if (!ld) begin
      chk("exec_alu_en", alu_en, 1);
      chk("exec_alu_a", alu_a, m_regs[rs1]);
      chk("exec_alu_b", alu_b, m_regs[rs2]);
      chk("exec_alu_sel", alu_sel, op);
      chk("exec_no_done", done, 0);
      chk("exec_not_ready", cmd_ready, 0);
      @(posedge clk); #1;
    end
    chk("wb_done", done, 1);
    chk("wb_zero", zero, (val == 0) ? 1 : 0);
    chk("wb_err", err, e);
    chk("wb_alu_en", alu_en, 0);
    dbg_addr = rd; #1;
    chk("wb_rd_not_yet", dbg_data, m_regs[rd]);
    o_zero = zero;
    o_err = err;
    @(posedge clk); #1;
    if (!e) m_regs[rd] = val;
    chk("idle_done_low", done, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_alu_en", alu_en, 0);
    sweep("regs_after_cmd");
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [3:0] imm;
    logic [3:0] exp_rd;
    logic       exp_zero;
    logic       exp_err;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic z, e;
    int acc [15];
    int a0;

    tbl[0]  = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'h7, 4'h7, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h3, 4'h3, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 2'd2, 2'd0, 2'd1, 4'h0, 4'hA, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'hF, 4'hF, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h1, 4'h1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 2'd3, 2'd0, 2'd1, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'h1, 2'd3, 2'd1, 2'd1, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 4'h5, 4'h5, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'h3, 2'd2, 2'd2, 2'd1, 4'h0, 4'h5, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h2, 4'h2, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'hB, 2'd2, 2'd2, 2'd1, 4'h0, 4'h1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'h6, 4'h6, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'h4, 2'd0, 2'd0, 2'd0, 4'h0, 4'h9, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'h4, 2'd0, 2'd0, 2'd0, 4'h0, 4'h6, 1'b0, 1'b0};

    // Reset values.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_alu_en", alu_en, 0);
    sweep("rst_regs");

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      issue(tbl[i].ld, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, z, e, acc[i]);
      chk("tbl_zero", z, tbl[i].exp_zero);
      chk("tbl_err", e, tbl[i].exp_err);
      dbg_addr = tbl[i].rd; #1;
      chk("tbl_rd_value", dbg_data, tbl[i].exp_rd);
    end
    chk("spacing_ld0_ld1", acc[1] - acc[0], 2);
    chk("spacing_ld1_add", acc[2] - acc[1], 2);
    chk("spacing_add_next", acc[3] - acc[2], 3);

    // Busy cycles: a different command held during EXEC/WB is taken only at the next IDLE.
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = 4'h0; cmd_rd = 2'd1; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0;
    @(posedge clk); #1;
    a0 = cyc;
    cmd_ld = 1'b1; cmd_rd = 2'd3; cmd_imm = 4'hC;
    chk("busy_exec_en", alu_en, 1);
    chk("busy_exec_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("busy_wb_done", done, 1);
    chk("busy_wb_ready", cmd_ready, 0);
    @(posedge clk); #1;
    m_regs[1] = m_regs[0] + m_regs[0];
    chk("busy_idle_done", done, 0);
    chk("busy_idle_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_accept_cycle", cyc - a0, 3);
    chk("busy_load_done", done, 1);
    @(posedge clk); #1;
    m_regs[3] = 4'hC;
    chk("busy_load_once", done, 0);
    @(posedge clk); #1;
    chk("busy_no_repeat", done, 0);
    sweep("busy_regs");

    // Reset mid-EXEC of ADD into r2.
    issue(1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 4'h9, z, e, a0);
    issue(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h4, z, e, a0);
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = 4'h0; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mid_exec_en", alu_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_alu_en", alu_en, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_done", done, 0);
    sweep("mid_rst_regs");
    @(posedge clk); #1;
    chk("mid_rst_no_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready_back", cmd_ready, 1);
    sweep("mid_rst_regs_after");
    issue(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'h2, z, e, a0);
    issue(1'b0, 4'h0, 2'd3, 2'd0, 2'd0, 4'h0, z, e, a0);

    // Random commands against the model.
    for (int i = 0; i < 60; i++) begin
      issue(($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), z, e, a0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
